// File: rtl/dmac_queued_engine_if.sv
// CPU register-slave bus and system-bus master signals of dmac_queued_engine.
// slave = the DMA block, master = the CPU / arbiter / memory side.
interface dmac_queued_engine_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              s_sel;
   logic              s_wr;
   logic [3:0]        s_addr;
   logic [DATA_W-1:0] s_din;
   logic [DATA_W-1:0] s_dout;
   logic              s_interrupt;
   logic              m_req;
   logic              m_grant;
   logic              m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_dout;
   logic [DATA_W-1:0] m_din;

   modport slave (
      input  s_sel, s_wr, s_addr, s_din, m_grant, m_din,
      output s_dout, s_interrupt, m_req, m_wr, m_addr, m_dout
   );
   modport master (
      output s_sel, s_wr, s_addr, s_din, m_grant, m_din,
      input  s_dout, s_interrupt, m_req, m_wr, m_addr, m_dout
   );
endinterface

// File: rtl/dmac_queued_engine.sv
// Queued DMA engine: register slave, descriptor FIFO and bus-master FSM in one block.
// Optional DMAC_ABORT_EN enables the ABORT register at offset 9.
module dmac_queued_engine #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   dmac_queued_engine_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] MODE_FSRC = 2'b01;
   localparam logic [1:0] MODE_FDST = 2'b10;
   localparam logic [1:0] MODE_FILL = 2'b11;

   typedef enum logic [2:0] {IDLE, POP, REQ, READ, WRITE, NEXT, DONE} state_t;
   typedef struct packed {
      logic [1:0]        mode;
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] size;
   } desc_t;

   state_t            state;
   desc_t             q_mem [FIFO_DEPTH];
   desc_t             head, cur;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] src_q, dst_q, size_q, dst_nxt;
   logic [1:0]        mode_q;
   logic              int_en, overflow, done, aborted, busy, abort_pend;
   logic              wr_en, empty, full, start, push_req, push_ok, pop, flush, done_clr, abort_now;

   assign wr_en    = bus.s_sel & bus.s_wr;
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign start    = wr_en && bus.s_addr == 4'd0 && bus.s_din[0];
   assign done_clr = wr_en && bus.s_addr == 4'd1 && bus.s_din == '0;
   assign push_req = wr_en && bus.s_addr == 4'd7 && bus.s_din[0];
   assign push_ok  = push_req && !full;
   assign pop      = (state == POP) && !empty;
`ifdef DMAC_ABORT_EN
   assign flush    = wr_en && bus.s_addr == 4'd9 && bus.s_din[0];
`else
   assign flush    = 1'b0;
`endif
   // an abort landing in the same cycle as a beat completion must still stop the run there
   assign abort_now = abort_pend | (flush & busy);
   assign head      = q_mem[rd_ptr];
   assign dst_nxt   = (cur.mode == MODE_FDST) ? cur.dst : cur.dst + ADDR_W'(1);
   assign bus.s_interrupt = done & int_en;

   always_ff @(posedge clk) begin
      if (push_ok && !flush) q_mem[wr_ptr] <= '{mode: mode_q, src: src_q, dst: dst_q, size: size_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_q    <= '0;
         dst_q    <= '0;
         size_q   <= '0;
         mode_q   <= '0;
         int_en   <= 1'b0;
         overflow <= 1'b0;
      end else if (wr_en) begin
         case (bus.s_addr)
            4'd1: if (done_clr) overflow <= 1'b0;
            4'd2: int_en <= bus.s_din[0];
            4'd3: src_q  <= bus.s_din[ADDR_W-1:0];
            4'd4: dst_q  <= bus.s_din[ADDR_W-1:0];
            4'd5: size_q <= bus.s_din[ADDR_W-1:0];
            4'd6: mode_q <= bus.s_din[1:0];
            4'd7: if (push_req && full) overflow <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.s_dout = '0;
      if (bus.s_sel && !bus.s_wr) begin
         case (bus.s_addr)
            4'd1: bus.s_dout = DATA_W'({aborted, done});
            4'd2: bus.s_dout = DATA_W'(int_en);
            4'd3: bus.s_dout = DATA_W'(src_q);
            4'd4: bus.s_dout = DATA_W'(dst_q);
            4'd5: bus.s_dout = DATA_W'(size_q);
            4'd6: bus.s_dout = DATA_W'(mode_q);
            4'd8: bus.s_dout = DATA_W'({overflow, busy, full, empty, count});
            default: bus.s_dout = '0;
         endcase
      end
   end

   // m_req is raised on entry to POP (by peeking the head) so it is low only in NEXT between descriptors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cur        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
         bus.m_req  <= 1'b0;
         bus.m_wr   <= 1'b0;
         bus.m_addr <= '0;
         bus.m_dout <= '0;
      end else begin
         if (done_clr) begin
            done    <= 1'b0;
            aborted <= 1'b0;
         end
         if (flush && busy) abort_pend <= 1'b1;
         case (state)
            IDLE: if (start && !empty) begin
               state     <= POP;
               busy      <= 1'b1;
               bus.m_req <= (head.size != '0);
            end
            POP: begin
               cur <= head;
               if (abort_now || head.size == '0) begin
                  state     <= abort_now ? DONE : NEXT;
                  bus.m_req <= 1'b0;
               end else begin
                  state <= REQ;
               end
            end
            REQ: if (abort_now) begin
               state     <= DONE;
               bus.m_req <= 1'b0;
            end else if (bus.m_grant) begin
               if (cur.mode == MODE_FILL) begin
                  state      <= WRITE;
                  bus.m_wr   <= 1'b1;
                  bus.m_addr <= cur.dst;
                  bus.m_dout <= DATA_W'(cur.src);
               end else begin
                  state      <= READ;
                  bus.m_wr   <= 1'b0;
                  bus.m_addr <= cur.src;
               end
            end
            READ: if (bus.m_grant) begin
               if (cur.mode != MODE_FSRC) cur.src <= cur.src + ADDR_W'(1);
               if (abort_now) begin
                  state     <= DONE;
                  bus.m_req <= 1'b0;
               end else begin
                  state      <= WRITE;
                  bus.m_wr   <= 1'b1;
                  bus.m_addr <= cur.dst;
                  bus.m_dout <= bus.m_din;
               end
            end
            WRITE: if (bus.m_grant) begin
               cur.dst  <= dst_nxt;
               cur.size <= cur.size - ADDR_W'(1);
               if (abort_now || cur.size == ADDR_W'(1)) begin
                  state     <= abort_now ? DONE : NEXT;
                  bus.m_req <= 1'b0;
                  bus.m_wr  <= 1'b0;
               end else if (cur.mode == MODE_FILL) begin
                  bus.m_addr <= dst_nxt;
               end else begin
                  state      <= READ;
                  bus.m_wr   <= 1'b0;
                  bus.m_addr <= cur.src;
               end
            end
            NEXT: if (abort_now || empty) begin
               state <= DONE;
            end else begin
               state     <= POP;
               bus.m_req <= (head.size != '0);
            end
            DONE: begin
               done       <= 1'b1;
               if (abort_pend) aborted <= 1'b1;
               abort_pend <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
